// File: rtl/door_pkg.sv
// Shared types for the door access controller: FSM state enum and the
// externally visible state_code encodings.
package door_pkg;

    localparam logic [1:0] CODE_LOCKED   = 2'd0;
    localparam logic [1:0] CODE_UNLOCKED = 2'd1;
    localparam logic [1:0] CODE_HELD     = 2'd2;
    localparam logic [1:0] CODE_LOCKOUT  = 2'd3;

    typedef enum logic [1:0] {
        ST_LOCKED   = CODE_LOCKED,
        ST_UNLOCKED = CODE_UNLOCKED,
        ST_HELD     = CODE_HELD,
        ST_LOCKOUT  = CODE_LOCKOUT
    } state_e;

endpackage

// File: rtl/door_timer.sv
// Loadable down-counter with a zero flag; shared by the unlock and lockout windows.
module door_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Load beats decrement; the count parks at zero instead of wrapping.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/door_access_ctrl.sv
// Door access controller: keypad/pushbutton unlock FSM with timed unlock window,
// ajar alarm and bad-PIN lockout. All outputs come straight from flops.
module door_access_ctrl
    import door_pkg::*;
#(
    parameter int unsigned UNLOCK_CYC  = 250_000_000,
    parameter int unsigned LOCKOUT_CYC = 1_500_000_000,
    parameter int unsigned MAX_FAIL    = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       booked,
    input  logic       pin_valid,
    input  logic       pin_ok,
    input  logic       pb_exit,
    input  logic       door_closed,
    output logic       lock_output,
    output logic       granted,
    output logic       denied,
    output logic       ajar_alarm,
    output logic [1:0] state_code
);

    localparam int unsigned MAX_CYC = (UNLOCK_CYC > LOCKOUT_CYC) ? UNLOCK_CYC : LOCKOUT_CYC;
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);
    localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYC - 1);
    localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYC - 1);
    localparam logic [2:0]    MAX_FAIL_C   = 3'(MAX_FAIL);

    state_e        state_d, state_q;
    logic          pb_q;
    logic          pb_edge;
    logic [2:0]    fail_d, fail_q;
    logic          pin_good;
    logic          grant_evt, deny_evt;
    logic          tmr_load, tmr_dec, tmr_zero;
    logic [TW-1:0] tmr_val;

    logic          lock_d, lock_q;
    logic          granted_d, granted_q;
    logic          denied_d, denied_q;
    logic          ajar_d, ajar_q;
    logic [1:0]    code_d, code_q;

    assign pb_edge  = pb_exit & ~pb_q;
    assign pin_good = pin_valid & pin_ok & ~booked;

    door_timer #(.WIDTH(TW)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    // State register (all flops, asynchronous reset engages the bolt at once)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_LOCKED;
            pb_q      <= 1'b0;
            fail_q    <= '0;
            lock_q    <= 1'b1;
            granted_q <= 1'b0;
            denied_q  <= 1'b0;
            ajar_q    <= 1'b0;
            code_q    <= CODE_LOCKED;
        end else begin
            state_q   <= state_d;
            pb_q      <= pb_exit;
            fail_q    <= fail_d;
            lock_q    <= lock_d;
            granted_q <= granted_d;
            denied_q  <= denied_d;
            ajar_q    <= ajar_d;
            code_q    <= code_d;
        end
    end

    // Next-state logic; a pushbutton edge always pre-empts a same-cycle PIN
    always_comb begin
        state_d   = state_q;
        fail_d    = fail_q;
        grant_evt = 1'b0;
        deny_evt  = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = UNLOCK_LOAD;
        tmr_dec   = 1'b0;
        unique case (state_q)
            ST_LOCKED: begin
                if (pb_edge) begin
                    state_d  = ST_UNLOCKED;
                    tmr_load = 1'b1;
                end else if (pin_good) begin
                    state_d   = ST_UNLOCKED;
                    tmr_load  = 1'b1;
                    grant_evt = 1'b1;
                    fail_d    = '0;
                end else if (pin_valid && pin_ok) begin
                    deny_evt = 1'b1;
                end else if (pin_valid) begin
                    deny_evt = 1'b1;
                    fail_d   = (fail_q < MAX_FAIL_C) ? fail_q + 3'd1 : fail_q;
                    if (fail_d == MAX_FAIL_C) begin
                        state_d  = ST_LOCKOUT;
                        tmr_load = 1'b1;
                        tmr_val  = LOCKOUT_LOAD;
                    end
                end
            end
            ST_UNLOCKED: begin
                tmr_dec = 1'b1;
                if (pb_edge || pin_good) begin
                    tmr_load  = 1'b1;
                    grant_evt = ~pb_edge;
                end else begin
                    deny_evt = pin_valid;
                    if (tmr_zero) begin
                        state_d = door_closed ? ST_LOCKED : ST_HELD;
                    end
                end
            end
            ST_HELD: begin
                if (door_closed) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKOUT: begin
                tmr_dec = 1'b1;
                if (pb_edge) begin
                    state_d  = ST_UNLOCKED;
                    tmr_load = 1'b1;
                    fail_d   = '0;
                end else begin
                    deny_evt = pin_valid;
                    if (tmr_zero) begin
                        state_d = ST_LOCKED;
                        fail_d  = '0;
                    end
                end
            end
            default: state_d = ST_LOCKED;
        endcase
    end

    // Output decode from the next state, so outputs land on the same edge
    always_comb begin
        lock_d    = (state_d == ST_LOCKED) || (state_d == ST_LOCKOUT);
        ajar_d    = (state_d == ST_HELD);
        code_d    = state_d;
        granted_d = grant_evt;
        denied_d  = deny_evt;
    end

    assign lock_output = lock_q;
    assign granted     = granted_q;
    assign denied      = denied_q;
    assign ajar_alarm  = ajar_q;
    assign state_code  = code_q;

endmodule

// File: tb/tb_door_access_ctrl.sv
// Directed bench for door_access_ctrl: expected output vectors are queued per
// step and compared after the following clock edge.
module tb_door_access_ctrl;

    logic       clk;
    logic       reset;
    logic       booked;
    logic       pin_valid;
    logic       pin_ok;
    logic       pb_exit;
    logic       door_closed;
    logic       lock_output;
    logic       granted;
    logic       denied;
    logic       ajar_alarm;
    logic [1:0] state_code;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // {lock_output, granted, denied, ajar_alarm, state_code}
    localparam logic [5:0] O_LOCKED   = 6'b1_0_0_0_00;
    localparam logic [5:0] O_DENY_L   = 6'b1_0_1_0_00;
    localparam logic [5:0] O_UNL      = 6'b0_0_0_0_01;
    localparam logic [5:0] O_GRANT    = 6'b0_1_0_0_01;
    localparam logic [5:0] O_HELD     = 6'b0_0_0_1_10;
    localparam logic [5:0] O_LOCKOUT  = 6'b1_0_0_0_11;
    localparam logic [5:0] O_DENY_LO  = 6'b1_0_1_0_11;

    logic [5:0] exp_q[$];
    string      tag_q[$];

    door_access_ctrl #(
        .UNLOCK_CYC  (10),
        .LOCKOUT_CYC (20),
        .MAX_FAIL    (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .booked      (booked),
        .pin_valid   (pin_valid),
        .pin_ok      (pin_ok),
        .pb_exit     (pb_exit),
        .door_closed (door_closed),
        .lock_output (lock_output),
        .granted     (granted),
        .denied      (denied),
        .ajar_alarm  (ajar_alarm),
        .state_code  (state_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare();
        logic [5:0] e;
        logic [5:0] obs;
        string      t;
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = {lock_output, granted, denied, ajar_alarm, state_code};
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b (lock,gr,dn,ajar,code)", t, obs, e);
        end
    endtask

    task automatic tick(input string tag, input logic [5:0] e);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic chk_fail(input string tag, input logic [2:0] e);
        checks++;
        assert (dut.fail_q === e) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, dut.fail_q, e);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; booked = 1'b0; pin_valid = 1'b0; pin_ok = 1'b0;
        pb_exit = 1'b0; door_closed = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_q.push_back(O_LOCKED); tag_q.push_back("reset_outputs");
        compare();
        chk_fail("reset_fail_cnt", 3'd0);
        reset = 1'b0;

        // Bad PIN counts, booked good PIN is refused without touching the count
        pin_valid = 1'b1; pin_ok = 1'b0;
        tick("bad_pin", O_DENY_L);
        pin_valid = 1'b0;
        chk_fail("bad_pin_cnt", 3'd1);
        pin_valid = 1'b1; pin_ok = 1'b1; booked = 1'b1;
        tick("booked_pin", O_DENY_L);
        pin_valid = 1'b0; booked = 1'b0;
        chk_fail("booked_cnt", 3'd1);
        tick("idle", O_LOCKED);

        // Good PIN: granted next cycle, bolt released for exactly 10 cycles
        pin_valid = 1'b1; pin_ok = 1'b1;
        tick("grant", O_GRANT);
        pin_valid = 1'b0;
        chk_fail("grant_clears_cnt", 3'd0);
        repeat (9) tick("unlock_window", O_UNL);
        tick("relock", O_LOCKED);

        // Three bad PINs -> lockout for 20 cycles
        pin_valid = 1'b1; pin_ok = 1'b0;
        tick("bad1", O_DENY_L);
        pin_valid = 1'b0;
        tick("idle", O_LOCKED);
        pin_valid = 1'b1;
        tick("bad2", O_DENY_L);
        pin_valid = 1'b0;
        chk_fail("cnt2", 3'd2);
        tick("idle", O_LOCKED);
        pin_valid = 1'b1;
        tick("bad3_lockout", O_DENY_LO);
        chk_fail("cnt3", 3'd3);
        tick("pin_in_lockout", O_DENY_LO);
        pin_valid = 1'b0;
        chk_fail("cnt_saturated", 3'd3);
        repeat (18) tick("lockout_window", O_LOCKOUT);
        tick("lockout_end", O_LOCKED);
        chk_fail("lockout_clears_cnt", 3'd0);

        // Door left open at expiry -> HELD with alarm; closing relocks
        pin_valid = 1'b1; pin_ok = 1'b1;
        tick("grant2", O_GRANT);
        pin_valid = 1'b0; door_closed = 1'b0;
        repeat (9) tick("unlock_open", O_UNL);
        tick("held", O_HELD);
        tick("held_stay", O_HELD);
        door_closed = 1'b1;
        tick("held_close", O_LOCKED);

        // Pushbutton overrides lockout; a held button gives only one event
        pin_valid = 1'b1; pin_ok = 1'b0;
        tick("b1", O_DENY_L);
        tick("b2", O_DENY_L);
        tick("b3", O_DENY_LO);
        pin_valid = 1'b0;
        repeat (3) tick("lockout", O_LOCKOUT);
        pb_exit = 1'b1;
        tick("pb_in_lockout", O_UNL);
        chk_fail("pb_exit_clears_cnt", 3'd0);
        repeat (9) tick("pb_held_level", O_UNL);
        tick("pb_relock", O_LOCKED);
        pb_exit = 1'b0;
        tick("idle", O_LOCKED);

        // Pushbutton coincident with good PIN: unlock without granted
        pb_exit = 1'b1; pin_valid = 1'b1; pin_ok = 1'b1;
        tick("pb_and_good_pin", O_UNL);
        pb_exit = 1'b0; pin_valid = 1'b0;
        repeat (4) tick("unlocked", O_UNL);
        pb_exit = 1'b1;
        tick("pb_reload", O_UNL);
        pb_exit = 1'b0;
        repeat (9) tick("reloaded_window", O_UNL);
        tick("relock_after_reload", O_LOCKED);

        // Pushbutton coincident with bad PIN: not counted, not denied
        pb_exit = 1'b1; pin_valid = 1'b1; pin_ok = 1'b0;
        tick("pb_and_bad_pin", O_UNL);
        pb_exit = 1'b0; pin_valid = 1'b0;
        chk_fail("pb_bad_pin_cnt", 3'd0);
        tick("mid_unlock", O_UNL);

        // Reset between clock edges re-engages the bolt immediately
        #2;
        reset = 1'b1;
        #1;
        exp_q.push_back(O_LOCKED); tag_q.push_back("async_reset");
        compare();
        @(posedge clk);
        #1;
        reset = 1'b0;
        tick("after_reset", O_LOCKED);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/door_access_ctrl.md
DOOR_ACCESS_CTRL -- requirements
Module: door_access_ctrl

Interface
REQ-001 Parameter UNLOCK_CYC, default 250_000_000, clock cycles the bolt stays released after a grant (5 s at 50 MHz).
REQ-002 Parameter LOCKOUT_CYC, default 1_500_000_000, clock cycles of keypad lockout (30 s).
REQ-003 Parameter MAX_FAIL, default 3, consecutive bad PINs that trigger lockout (range 1..7).
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 booked  input  1  level; room currently booked, so keypad entry is refused.
REQ-007 pin_valid  input  1  one-cycle strobe; a PIN entry completed.
REQ-008 pin_ok  input  1  qualified by pin_valid; 1 means the PIN matched.
REQ-009 pb_exit  input  1  debounced, synchronous level from the inside exit pushbutton.
REQ-010 door_closed  input  1  level; 1 means the door sensor reports closed.
REQ-011 lock_output  output  1  1 means the bolt is engaged.
REQ-012 granted  output  1  one-cycle pulse on each accepted unlock.
REQ-013 denied  output  1  one-cycle pulse on each refused PIN.
REQ-014 ajar_alarm  output  1  level; door left open after the unlock window.
REQ-015 state_code  output  2  current FSM state: LOCKED=0, UNLOCKED=1, HELD=2, LOCKOUT=3.

Function
REQ-016 All outputs SHALL be registered, and each SHALL reflect a triggering input one cycle after the clock edge that samples it.
REQ-017 pb_exit SHALL be rising-edge detected internally; a held level SHALL cause only one event.
REQ-018 The FSM SHALL have four states: LOCKED, UNLOCKED, HELD and LOCKOUT.
REQ-019 In LOCKED, lock_output=1.
- pb edge -> UNLOCKED.
- pin_valid&pin_ok&!booked -> UNLOCKED, granted pulse, fail_cnt cleared.
REQ-020 In LOCKED, pin_valid&pin_ok&booked SHALL pulse denied, SHALL NOT change fail_cnt, and SHALL remain in LOCKED.
REQ-021 In LOCKED, pin_valid&!pin_ok SHALL pulse denied and increment a 3-bit fail_cnt.
- If the new count equals MAX_FAIL, the FSM SHALL enter LOCKOUT.
REQ-022 In UNLOCKED, lock_output=0 and the timer SHALL be loaded with UNLOCK_CYC-1 on entry, then count down once per cycle.
REQ-023 In UNLOCKED, a new pb edge or accepted PIN SHALL reload the timer; an accepted PIN SHALL also pulse granted.
REQ-024 On UNLOCKED timer reaching 0, the FSM SHALL enter LOCKED if door_closed=1, otherwise HELD.
REQ-025 In HELD, lock_output=0 and ajar_alarm=1; door_closed=1 SHALL transition to LOCKED and clear ajar_alarm in the same edge.
REQ-026 In LOCKOUT, lock_output=1 and the timer SHALL be loaded with LOCKOUT_CYC-1 on entry.
- Every pin_valid SHALL pulse denied.
- A timer value of 0 SHALL transition to LOCKED.
REQ-027 In LOCKOUT, a pb edge SHALL transition to UNLOCKED, because egress always overrides lockout.
REQ-028 Exit from LOCKOUT by either path SHALL clear fail_cnt.
REQ-029 When a pb edge and pin_valid occur in the same cycle, the pb edge SHALL win, and the PIN SHALL be neither counted nor acknowledged.
REQ-030 fail_cnt SHALL saturate at MAX_FAIL and SHALL never wrap.
REQ-031 The timer SHALL be wide enough for max(UNLOCK_CYC, LOCKOUT_CYC) and SHALL never underflow.

Reset
REQ-032 Reset SHALL force LOCKED, lock_output=1, granted=0, denied=0, ajar_alarm=0, state_code=0, fail_cnt=0, timer=0 and the pb edge register=0.
REQ-033 Reset asserted mid-unlock or mid-lockout SHALL re-engage the bolt immediately (asynchronously), without waiting for a clock edge.

Structure
REQ-034 Package door_pkg SHALL hold the state enum and the state_code encodings.
REQ-035 Sub-module door_timer (loadable down-counter with a zero flag, parameterised width) SHALL implement both timing windows.

Verification (UNLOCK_CYC=10, LOCKOUT_CYC=20, MAX_FAIL=3)
REQ-036 Good PIN, booked=0, door_closed=1 -> granted pulse next cycle, lock_output=0 for exactly 10 cycles, then 1.
REQ-037 Good PIN with booked=1 -> denied pulse, lock_output stays 1, fail_cnt unchanged.
REQ-038 Three bad PINs -> state_code=3 after the third, fourth PIN denied, LOCKED after 20 cycles, fail_cnt=0.
REQ-039 door_closed=0 at unlock expiry -> state_code=2, ajar_alarm=1; door_closed=1 -> LOCKED next cycle.
REQ-040 pb edge during LOCKOUT, and pb edge coincident with a good PIN -> UNLOCKED with no granted pulse; reset mid-UNLOCKED -> lock_output=1 asynchronously.
